// File: rtl/front_panel_scanner.sv
// front_panel_scanner
// Input side of the Altair front panel. Every raw pin (8 sense switches,
// 7 buttons, 4 slide switches) is synchronised and debounced. The block then
// produces clean levels and one-cycle, priority-resolved command pulses for the
// core. A shared auto-repeat engine drives examine_next / deposit_next.
module front_panel_scanner #(
  parameter int DEBOUNCE_CYCLES = 250000,   // cycles a new pin value must hold (>=1)
  parameter int REPEAT_DELAY    = 12500000, // hold time before auto-repeat; 0 disables it
  parameter int REPEAT_PERIOD   = 2500000   // cycles between auto-repeat pulses (>=1)
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] sense_raw,
  input  logic [6:0] btn_raw,
  input  logic [3:0] sw_raw,
  output logic [7:0] sense,
  output logic       sense_changed,
  output logic       pause_mode,
  output logic       step_pulse,
  output logic       examine_pulse,
  output logic       examine_next_pulse,
  output logic       deposit_pulse,
  output logic       deposit_next_pulse,
  output logic       reset_pulse,
  output logic       reset_hold
);

  // Pin vector layout: [7:0] sense, [14:8] buttons, [18:15] slide switches.
  localparam int NBITS = 19;

  // Idle level of every pin: switches off, buttons released. btn[0] is active
  // low, so its released level is 1.
  localparam logic [NBITS-1:0] RST_VAL = {4'h0, 7'h01, 8'h00};

  // XOR mask that turns button stable levels into "pressed" flags.
  localparam logic [6:0] BTN_ACTIVE_LOW = 7'h01;

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam int             TMAX        = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                          : REPEAT_PERIOD;
  localparam int             TW          = $clog2(TMAX + 1);
  localparam logic [TW-1:0]  DELAY_LAST  = TW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [TW-1:0]  PERIOD_LAST = TW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_DELAY,
    RPT_REPEAT
  } rpt_state_t;

  typedef enum logic {
    OWN_EXAMINE_NEXT,
    OWN_DEPOSIT_NEXT
  } rpt_owner_t;

  logic [NBITS-1:0] raw_all;
  logic [NBITS-1:0] sync_q1;
  logic [NBITS-1:0] sync_q2;
  logic [NBITS-1:0] stable;
  logic [CW-1:0]    db_cnt [NBITS];
  logic [14:0]      stable_prev;

  logic [6:0] pressed;
  logic [6:0] pressed_prev;
  logic [6:0] press_evt;

  logic sel_reset;
  logic sel_dep_next;
  logic sel_dep;
  logic sel_ex_next;
  logic sel_ex;
  logic sel_step;

  rpt_state_t     rpt_state;
  rpt_state_t     rpt_state_nxt;
  rpt_owner_t     rpt_owner;
  rpt_owner_t     rpt_owner_nxt;
  logic [TW-1:0]  rpt_timer;
  logic [TW-1:0]  rpt_timer_nxt;
  logic           rpt_fire;
  logic           owner_released;

  logic unused_inputs;

  assign raw_all = {sw_raw, btn_raw, sense_raw};

  // Two-flop synchroniser for all pins; it resets to the idle pin levels.
  // NOTE: every clocked block uses non-blocking (<=) assignments so all flops
  // sample pre-edge values; blocking assignments here would collapse the chain.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q1 <= RST_VAL;
      sync_q2 <= RST_VAL;
    end else begin
      sync_q1 <= raw_all;
      sync_q2 <= sync_q1;
    end
  end

  // Per-bit debounce: count while sync differs from stable, accept on the last count.
  // NOTE: the counter array is reset explicitly. It is a bank of flops, not a
  // RAM, and an abort mid-debounce must leave no partial count behind.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stable <= RST_VAL;
      for (int i = 0; i < NBITS; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NBITS; i++) begin
        if (sync_q2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_LAST) begin
          stable[i] <= sync_q2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CW'(1);
        end
      end
    end
  end

  // One-cycle-delayed copy of the sense/button levels for edge detection.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stable_prev <= RST_VAL[14:0];
    end else begin
      stable_prev <= stable[14:0];
    end
  end

  assign pressed      = stable[14:8] ^ BTN_ACTIVE_LOW;
  assign pressed_prev = stable_prev[14:8] ^ BTN_ACTIVE_LOW;
  assign press_evt    = pressed & ~pressed_prev;

  assign sense      = stable[7:0];
  assign pause_mode = ~stable[15];
  assign reset_hold = pressed[0];

  // Slide switches [3:1] and button 6 are debounced but have no consumer yet.
  assign unused_inputs = ^{stable[18:16], press_evt[6]};

  // Priority resolution of same-cycle presses; a held reset masks everything else.
  // NOTE: each always_comb output gets a default first, so no path can leave a
  // signal unassigned and infer a latch.
  always_comb begin
    sel_reset    = 1'b0;
    sel_dep_next = 1'b0;
    sel_dep      = 1'b0;
    sel_ex_next  = 1'b0;
    sel_ex       = 1'b0;
    sel_step     = 1'b0;
    if (press_evt[0]) begin
      sel_reset = 1'b1;
    end else if (!reset_hold) begin
      if (press_evt[5]) begin
        sel_dep_next = 1'b1;
      end else if (press_evt[4]) begin
        sel_dep = 1'b1;
      end else if (press_evt[3]) begin
        sel_ex_next = 1'b1;
      end else if (press_evt[2]) begin
        sel_ex = 1'b1;
      end else if (press_evt[1]) begin
        sel_step = 1'b1;
      end
    end
  end

  assign owner_released = (rpt_owner == OWN_DEPOSIT_NEXT) ? ~pressed[5] : ~pressed[3];

  // Auto-repeat state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rpt_state <= RPT_IDLE;
      rpt_owner <= OWN_EXAMINE_NEXT;
      rpt_timer <= '0;
    end else begin
      rpt_state <= rpt_state_nxt;
      rpt_owner <= rpt_owner_nxt;
      rpt_timer <= rpt_timer_nxt;
    end
  end

  // Auto-repeat next state: the owner is claimed by its press pulse; release or reset_hold abort.
  always_comb begin
    rpt_state_nxt = rpt_state;
    rpt_owner_nxt = rpt_owner;
    rpt_timer_nxt = rpt_timer;
    rpt_fire      = 1'b0;
    unique case (rpt_state)
      RPT_IDLE: begin
        if (REPEAT_DELAY != 0) begin
          if (sel_dep_next) begin
            rpt_state_nxt = RPT_DELAY;
            rpt_owner_nxt = OWN_DEPOSIT_NEXT;
            rpt_timer_nxt = '0;
          end else if (sel_ex_next) begin
            rpt_state_nxt = RPT_DELAY;
            rpt_owner_nxt = OWN_EXAMINE_NEXT;
            rpt_timer_nxt = '0;
          end
        end
      end
      RPT_DELAY: begin
        if (owner_released || reset_hold) begin
          rpt_state_nxt = RPT_IDLE;
          rpt_timer_nxt = '0;
        end else if (rpt_timer == DELAY_LAST) begin
          rpt_fire      = 1'b1;
          rpt_state_nxt = RPT_REPEAT;
          rpt_timer_nxt = '0;
        end else begin
          rpt_timer_nxt = rpt_timer + TW'(1);
        end
      end
      RPT_REPEAT: begin
        if (owner_released || reset_hold) begin
          rpt_state_nxt = RPT_IDLE;
          rpt_timer_nxt = '0;
        end else if (rpt_timer == PERIOD_LAST) begin
          rpt_fire      = 1'b1;
          rpt_timer_nxt = '0;
        end else begin
          rpt_timer_nxt = rpt_timer + TW'(1);
        end
      end
      default: begin
        rpt_state_nxt = RPT_IDLE;
        rpt_timer_nxt = '0;
      end
    endcase
  end

  // Registered one-cycle command pulses and the sense-change strobe.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sense_changed      <= 1'b0;
      step_pulse         <= 1'b0;
      examine_pulse      <= 1'b0;
      examine_next_pulse <= 1'b0;
      deposit_pulse      <= 1'b0;
      deposit_next_pulse <= 1'b0;
      reset_pulse        <= 1'b0;
    end else begin
      sense_changed      <= (stable[7:0] != stable_prev[7:0]);
      step_pulse         <= sel_step;
      examine_pulse      <= sel_ex;
      examine_next_pulse <= sel_ex_next | (rpt_fire && (rpt_owner == OWN_EXAMINE_NEXT));
      deposit_pulse      <= sel_dep;
      deposit_next_pulse <= sel_dep_next | (rpt_fire && (rpt_owner == OWN_DEPOSIT_NEXT));
      reset_pulse        <= sel_reset;
    end
  end

endmodule

// File: tb/tb_front_panel_scanner.sv
// Directed bench for front_panel_scanner with short debounce/repeat timings.
// Inputs change on the falling edge and outputs are sampled on the falling edge.
// Cycle numbers count falling edges since the last clear_counts().
module tb_front_panel_scanner;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] sense_raw;
  logic [6:0] btn_raw;
  logic [3:0] sw_raw;
  logic [7:0] sense;
  logic       sense_changed;
  logic       pause_mode;
  logic       step_pulse;
  logic       examine_pulse;
  logic       examine_next_pulse;
  logic       deposit_pulse;
  logic       deposit_next_pulse;
  logic       reset_pulse;
  logic       reset_hold;

  int n_vec = 0;
  int n_err = 0;

  // Per-output pulse counts and first-pulse cycle:
  // 0 step, 1 examine, 2 examine_next, 3 deposit, 4 deposit_next, 5 reset, 6 sense_changed.
  int cnt_p   [7];
  int first_p [7];
  int cyc;
  int dn_times [$];

  front_panel_scanner #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (20),
    .REPEAT_PERIOD   (5)
  ) dut (
    .clk                (clk),
    .resetn             (resetn),
    .sense_raw          (sense_raw),
    .btn_raw            (btn_raw),
    .sw_raw             (sw_raw),
    .sense              (sense),
    .sense_changed      (sense_changed),
    .pause_mode         (pause_mode),
    .step_pulse         (step_pulse),
    .examine_pulse      (examine_pulse),
    .examine_next_pulse (examine_next_pulse),
    .deposit_pulse      (deposit_pulse),
    .deposit_next_pulse (deposit_next_pulse),
    .reset_pulse        (reset_pulse),
    .reset_hold         (reset_hold)
  );

  always #20 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [6:0] pulse_vec();
    return {sense_changed, reset_pulse, deposit_next_pulse, deposit_pulse,
            examine_next_pulse, examine_pulse, step_pulse};
  endfunction

  task automatic clear_counts();
    cyc = 0;
    for (int i = 0; i < 7; i++) begin
      cnt_p[i]   = 0;
      first_p[i] = -1;
    end
    dn_times.delete();
  endtask

  task automatic observe(input int n);
    logic [6:0] pv;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      cyc++;
      pv = pulse_vec();
      for (int b = 0; b < 7; b++) begin
        if (pv[b]) begin
          cnt_p[b]++;
          if (first_p[b] < 0) first_p[b] = cyc;
        end
      end
      if (pv[4]) dn_times.push_back(cyc);
    end
  endtask

  function automatic int cmd_pulses();
    int s = 0;
    for (int i = 0; i < 6; i++) s += cnt_p[i];
    return s;
  endfunction

  initial begin
    int exp_dn [$];
    int got_t;

    resetn    = 1'b0;
    sense_raw = 8'h00;
    btn_raw   = 7'h01;
    sw_raw    = 4'h0;

    // 1. Reset values, then 50 quiet cycles.
    repeat (3) @(negedge clk);
    check("rst_sense",      32'(sense), 32'h00);
    check("rst_pause_mode", 32'(pause_mode), 32'd1);
    check("rst_pulses",     32'(pulse_vec()), 32'd0);
    check("rst_reset_hold", 32'(reset_hold), 32'd0);
    resetn = 1'b1;
    clear_counts();
    observe(50);
    check("idle_pulses", 32'(cmd_pulses() + cnt_p[6]), 32'd0);
    check("idle_pause",  32'(pause_mode), 32'd1);
    check("idle_sense",  32'(sense), 32'h00);

    // 2. Sense switches: clean edge lands after 6 cycles; a 3-cycle glitch is ignored.
    clear_counts();
    sense_raw = 8'hA5;
    observe(5);
    check("sense_before_accept", 32'(sense), 32'h00);
    observe(1);
    check("sense_accept", 32'(sense), 32'hA5);
    observe(10);
    check("sense_changed_count", 32'(cnt_p[6]), 32'd1);
    check("sense_changed_cycle", 32'(first_p[6]), 32'd7);
    clear_counts();
    sense_raw = 8'hFF;
    observe(3);
    sense_raw = 8'hA5;
    observe(12);
    check("glitch_sense",         32'(sense), 32'hA5);
    check("glitch_sense_changed", 32'(cnt_p[6]), 32'd0);

    // Slide switch 0 drives pause_mode low once debounced.
    sw_raw = 4'h1;
    observe(5);
    check("pause_before_accept", 32'(pause_mode), 32'd1);
    observe(1);
    check("pause_accept", 32'(pause_mode), 32'd0);

    // 3. Examine button: single pulse 7 cycles after the edge, nothing on release.
    clear_counts();
    btn_raw = 7'h05;
    observe(10);
    btn_raw = 7'h01;
    check("examine_count", 32'(cnt_p[1]), 32'd1);
    check("examine_cycle", 32'(first_p[1]), 32'd7);
    check("examine_only",  32'(cmd_pulses()), 32'd1);
    clear_counts();
    observe(12);
    check("examine_release", 32'(cmd_pulses()), 32'd0);

    // Button glitch shorter than the debounce window.
    clear_counts();
    btn_raw = 7'h03;
    observe(3);
    btn_raw = 7'h01;
    observe(12);
    check("step_glitch", 32'(cmd_pulses()), 32'd0);

    // 4. deposit_next held 60 cycles: press at 7, repeat at 27, then every 5.
    //    Release reaches stable at 66; the repeat due at 67 is dropped.
    clear_counts();
    btn_raw = 7'h21;
    observe(60);
    btn_raw = 7'h01;
    observe(20);
    exp_dn = '{7, 27, 32, 37, 42, 47, 52, 57, 62};
    check("dn_repeat_count", 32'(dn_times.size()), 32'(exp_dn.size()));
    for (int i = 0; i < exp_dn.size(); i++) begin
      got_t = (i < dn_times.size()) ? dn_times[i] : -1;
      check($sformatf("dn_repeat_t%0d", i), 32'(got_t), 32'(exp_dn[i]));
    end
    check("dn_repeat_others", 32'(cmd_pulses() - cnt_p[4]), 32'd0);

    // 5a. step and deposit pressed together: only deposit pulses.
    clear_counts();
    btn_raw = 7'h13;
    observe(12);
    btn_raw = 7'h01;
    observe(12);
    check("prio_deposit", 32'(cnt_p[3]), 32'd1);
    check("prio_step",    32'(cnt_p[0]), 32'd0);
    check("prio_total",   32'(cmd_pulses()), 32'd2 - 32'd1);

    // 5b. reset pressed with examine_next rising: only reset, reset_hold high.
    clear_counts();
    btn_raw = 7'h08;
    observe(12);
    check("prio_reset_pulse",  32'(cnt_p[5]), 32'd1);
    check("prio_reset_cycle",  32'(first_p[5]), 32'd7);
    check("prio_reset_ex_nxt", 32'(cnt_p[2]), 32'd0);
    check("reset_hold_on",     32'(reset_hold), 32'd1);
    btn_raw = 7'h01;
    observe(12);
    check("reset_hold_off",      32'(reset_hold), 32'd0);
    check("reset_release_quiet", 32'(cmd_pulses()), 32'd1);

    // 6. resetn asserted mid-repeat, then released with deposit_next still held.
    clear_counts();
    btn_raw = 7'h21;
    observe(30);
    check("pre_abort_repeat", 32'(dn_times.size()), 32'd2);
    resetn = 1'b0;
    #1;
    check("abort_pulses", 32'(pulse_vec()), 32'd0);
    check("abort_sense",  32'(sense), 32'h00);
    check("abort_pause",  32'(pause_mode), 32'd1);
    check("abort_hold",   32'(reset_hold), 32'd0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    clear_counts();
    observe(40);
    exp_dn = '{7, 27, 32, 37};
    check("resume_count", 32'(dn_times.size()), 32'(exp_dn.size()));
    for (int i = 0; i < exp_dn.size(); i++) begin
      got_t = (i < dn_times.size()) ? dn_times[i] : -1;
      check($sformatf("resume_t%0d", i), 32'(got_t), 32'(exp_dn[i]));
    end
    check("resume_sense", 32'(sense), 32'hA5);
    check("resume_pause", 32'(pause_mode), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
